t05_sd_spi_engine: RTL

Parametrised SPI-mode SD card command/response engine replacing the fixed-sequence SD SPI controller. It generates its own SCK from `clk` and computes CRC7 in hardware, so any CMDn/ACMDn can be issued. It returns variable-length R1/R3/R7 responses with a response timeout, and provides a byte-stream data port for block reads and writes. It sits between the team's SD/file-transfer FSM and the SD card pins.

---
 rtl/t05_sd_spi_engine.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/t05_sd_spi_engine.sv
// SPI-mode SD card command/response engine.
//   Generates SCK (mode 0) from clk, frames CMDn with a hardware CRC7,
//   collects 1..5 byte responses with an Ncr poll timeout, and offers a
//   single-byte full-duplex transfer port for data blocks.
// Ports:
//   clk, nrst                     clock, asynchronous active-low reset
//   sck, cs_n, mosi, miso         SD card SPI pins
//   init_req, release_req         warmup clocks / close session (pulses)
//   cmd_valid/ready, cmd_*        command request (index, argument, resp length)
//   resp_valid/data/timeout       response result (pulse, right-justified data)
//   xfer_valid/ready, xfer_tx     byte transfer request
//   rx_valid, rx_data             received byte of a transfer
//   busy                          engine not idle
`timescale 1ns/1ps
module t05_sd_spi_engine #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned WARMUP_SCK = 80,
  parameter int unsigned NCR_MAX    = 8
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  input  logic        init_req,
  input  logic        release_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [2:0]  cmd_resp_len,
  output logic        resp_valid,
  output logic [39:0] resp_data,
  output logic        resp_timeout,
  input  logic        xfer_valid,
  input  logic [7:0]  xfer_tx,
  output logic        xfer_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        busy
);

  localparam int unsigned   DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [15:0]   WARM_BITS = 16'(WARMUP_SCK);
  localparam logic [15:0]   POLL_BITS = 16'(NCR_MAX * 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_CMD_TX,
    S_RESP_WAIT,
    S_RESP_RX,
    S_XFER,
    S_TRAILER
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [47:0]   tx_q, tx_d;
  logic [39:0]   rx_q, rx_d;
  logic [2:0]    len_q, len_d;
  logic          session_q, session_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_timeout_q, resp_timeout_d;
  logic [39:0]   resp_data_q, resp_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;

  logic          active, tick, rise, fall;
  logic [2:0]    len_clamped;
  logic [39:0]   cmd_head;

  // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0]  c;
    logic [39:0] s;
    logic        fb;
    c = '0;
    s = data;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = s[39] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
      s  = {s[38:0], 1'b0};
    end
    return c;
  endfunction

  assign cmd_head = {2'b01, cmd_index, cmd_arg};

  always_comb begin
    len_clamped = cmd_resp_len;
    if (cmd_resp_len == 3'd0)      len_clamped = 3'd1;
    else if (cmd_resp_len > 3'd5)  len_clamped = 3'd5;
  end

  assign active = (state_q != S_IDLE);
  assign tick   = (div_q == DIV_LAST);
  assign rise   = active && tick && !sck_q;   // MISO sampling edge
  assign fall   = active && tick &&  sck_q;   // bit boundary, MOSI advances

  always_comb begin
    state_d        = state_q;
    div_d          = '0;
    sck_d          = sck_q;
    cnt_d          = cnt_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    len_d          = len_q;
    session_d      = session_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = 1'b0;
    resp_data_d    = resp_data_q;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data_q;

    if (active) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) sck_d = ~sck_q;
    end

    unique case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        if (init_req) begin
          state_d   = S_WARMUP;
          session_d = 1'b0;
          cnt_d     = WARM_BITS;
        end else if (release_req && session_q) begin
          state_d = S_TRAILER;
          cnt_d   = 16'd8;
        end else if (cmd_valid) begin
          state_d   = S_CMD_TX;
          session_d = 1'b1;
          tx_d      = {cmd_head, crc7(cmd_head), 1'b1};
          len_d     = len_clamped;
          cnt_d     = 16'd48;
        end else if (xfer_valid && session_q) begin
          state_d = S_XFER;
          tx_d    = {xfer_tx, 40'hFF_FFFF_FFFF};
          rx_d    = '0;
          cnt_d   = 16'd8;
        end
      end

      S_WARMUP, S_TRAILER: begin
        if (fall) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_d = S_IDLE;
            if (state_q == S_TRAILER) session_d = 1'b0;
          end
        end
      end

      S_CMD_TX: begin
        if (fall) begin
          tx_d  = {tx_q[46:0], 1'b1};
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_RESP_WAIT;
            cnt_d   = POLL_BITS;
          end
        end
      end

      S_RESP_WAIT: begin
        // A zero bit is the response MSB, so it counts as the first
        // received bit and the remaining count excludes it.
        if (rise && !miso) begin
          state_d = S_RESP_RX;
          rx_d    = '0;
          cnt_d   = {10'd0, len_q, 3'b000} - 16'd1;
        end else if (fall) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_d        = S_IDLE;
            resp_data_d    = '1;
            resp_valid_d   = 1'b1;
            resp_timeout_d = 1'b1;
          end
        end
      end

      S_RESP_RX: begin
        if (rise) begin
          rx_d  = {rx_q[38:0], miso};
          cnt_d = cnt_q - 16'd1;
        end else if (fall && (cnt_q == 16'd0)) begin
          state_d      = S_IDLE;
          resp_data_d  = rx_q;
          resp_valid_d = 1'b1;
        end
      end

      S_XFER: begin
        if (rise) begin
          rx_d = {rx_q[38:0], miso};
        end else if (fall) begin
          tx_d  = {tx_q[46:0], 1'b1};
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d    = S_IDLE;
            rx_data_d  = rx_q[7:0];
            rx_valid_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      sck_q          <= 1'b0;
      cnt_q          <= '0;
      tx_q           <= '1;
      rx_q           <= '0;
      len_q          <= 3'd1;
      session_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      sck_q          <= sck_d;
      cnt_q          <= cnt_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      len_q          <= len_d;
      session_q      <= session_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_data_q    <= resp_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
    end
  end

  assign sck          = sck_q;
  // Trailer clocks run with CS already high; the session flag itself only
  // drops once the trailer has finished.
  assign cs_n         = !(session_q && (state_q != S_TRAILER));
  assign mosi         = ((state_q == S_CMD_TX) || (state_q == S_XFER)) ? tx_q[47] : 1'b1;
  assign cmd_ready    = (state_q == S_IDLE);
  assign xfer_ready   = (state_q == S_IDLE) && session_q;
  assign busy         = (state_q != S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_data    = resp_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;

endmodule
